// File: rtl/uart_prog_loader.sv
// UART boot loader: receives an A5/count/words/checksum frame and writes words to instruction ROM.
// Write strobe lands one cycle after each 4th data byte; no backpressure, ROM must accept every strobe.
module uart_prog_loader #(
  parameter int BAUD_DIV  = 434,
  parameter int MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rx_pin,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        hold_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [16:0]   MAXW    = 17'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  logic          sync1_q, sync2_q, rx_prev_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_vld_q, rx_vld_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          baud_tick;

  state_t        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   idx_q, idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   n_words;
  logic          in_load;

  assign baud_tick = (baud_cnt_q == '0);

  always_comb begin
    rx_state_d = rx_state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_vld_d   = 1'b0;
    rx_ferr_d  = 1'b0;
    if (baud_cnt_q != '0) baud_cnt_d = baud_cnt_q - 1'b1;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !sync2_q) begin
          rx_state_d = RX_START;
          baud_cnt_d = HALF_M1;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (baud_tick) begin
          if (sync2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            baud_cnt_d = FULL_M1;
            bit_cnt_d  = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (baud_tick) begin
          shift_d    = {sync2_q, shift_q[7:1]};
          baud_cnt_d = FULL_M1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (baud_tick) begin
          rx_state_d = RX_IDLE;
          rx_vld_d   = sync2_q;
          rx_ferr_d  = !sync2_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!en) begin
      rx_state_d = RX_IDLE;
      rx_vld_d   = 1'b0;
      rx_ferr_d  = 1'b0;
    end
  end

  assign n_words = {shift_q, count_q[7:0]};
  assign in_load = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                   (state_q == S_DATA)   || (state_q == S_CSUM);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (rx_vld_q && shift_q == 8'hA5) begin
          state_d = S_CNT_LO;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_CNT_LO: begin
        if (rx_vld_q) begin
          count_d[7:0] = shift_q;
          state_d      = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (rx_vld_q) begin
          count_d    = n_words;
          idx_d      = 16'd0;
          byte_idx_d = 2'd0;
          csum_d     = 8'd0;
          if (n_words == 16'd0 || {1'b0, n_words} > MAXW) state_d = S_ERR;
          else state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_vld_q) begin
          word_d     = {shift_q, word_q[31:8]};
          csum_d     = csum_q + shift_q;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = {14'd0, idx_q, 2'b00};
            data_d = {shift_q, word_q[31:8]};
            idx_d  = idx_q + 16'd1;
            if (idx_q == count_q - 16'd1) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (rx_vld_q) state_d = (shift_q == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
    if (rx_ferr_q && in_load) state_d = S_ERR;
    if (state_d == S_ERR)  err_d  = 1'b1;
    if (state_d == S_DONE) done_d = 1'b1;
    // Dropping en abandons the load but keeps the result flags and prior writes.
    if (!en) begin
      state_d = S_IDLE;
      we_d    = 1'b0;
      done_d  = done_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      rx_vld_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      state_q    <= S_IDLE;
      count_q    <= 16'd0;
      idx_q      <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      csum_q     <= 8'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= rx_pin;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      rx_state_q <= rx_state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_vld_q   <= rx_vld_d;
      rx_ferr_q  <= rx_ferr_d;
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign hold_o     = in_load;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
